// File: rtl/proc_seq_if.sv
// Processor-side bus of the program sequencer: instruction/immediate word,
// Run strobe and the core's Done reply.
interface proc_seq_if;
   logic [8:0] din;
   logic       run;
   logic       done;

   modport master (output din, output run, input done);
   modport slave  (input din, input run, output done);
endinterface

// File: rtl/proc_sequencer.sv
// Program sequencer for the 9-bit multicycle processor: program RAM, fetch/run/wait-for-Done loop.
// Optional single-step mode with input i_step when PROC_SEQ_STEP_EN is defined.
//
// state | meaning
// IDLE  | after reset; RAM loadable, waiting for Start
// FETCH | DIN = RAM[PC], Run pulsed (Run held low if a trailing mvi has no immediate)
// EXEC  | waiting for Done; DIN carries the immediate for mvi; timeout counter running
// PAUSE | (step build only) between instructions, waiting for a Step rising edge
// HALT  | program finished or error; RAM loadable, Start re-runs
module proc_sequencer #(
   parameter int DEPTH   = 32,
   parameter int AW      = 5,
   parameter int TIMEOUT = 7
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load_en,
   input  logic [AW-1:0] i_load_addr,
   input  logic [8:0]    i_load_data,
   input  logic [AW:0]   i_prog_len,
   input  logic          i_start,
`ifdef PROC_SEQ_STEP_EN
   input  logic          i_step,
`endif
   proc_seq_if.master    bus,
   output logic [AW-1:0] o_pc,
   output logic          o_busy,
   output logic          o_halted,
   output logic          o_error
);

   localparam logic [2:0] OP_MVI = 3'b001;
   localparam int         CW     = $clog2(TIMEOUT + 1);

`ifdef PROC_SEQ_STEP_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_PAUSE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`endif

   state_t        r_state;
   logic [8:0]    r_ram [DEPTH];
   logic [AW:0]   r_pc;
   logic [AW:0]   r_len;
   logic [8:0]    r_din;
   logic          r_run;
   logic          r_busy;
   logic          r_halted;
   logic          r_error;
   logic          r_mvi;
   logic [CW-1:0] r_wait;

   logic [AW:0]   w_next_pc;
   logic [AW-1:0] w_imm_addr;
   logic [8:0]    w_next_word;
   logic          w_load_ok;

   // A trailing mvi whose immediate lies past the program end must not be run.
   function automatic logic fetch_ok(input logic [2:0] op, input logic [AW:0] pc_p1,
                                     input logic [AW:0] len);
      return !((op == OP_MVI) && (pc_p1 >= len));
   endfunction

   assign w_next_pc   = r_pc + (r_mvi ? (AW+1)'(2) : (AW+1)'(1));
   assign w_imm_addr  = r_pc[AW-1:0] + AW'(1);
   assign w_next_word = r_ram[w_next_pc[AW-1:0]];
   assign w_load_ok   = (r_state == S_IDLE) || (r_state == S_HALT);

`ifdef PROC_SEQ_STEP_EN
   logic          r_step_d;
   logic          w_step_rise;
   logic [AW:0]   w_pc_p1;
   logic [8:0]    w_cur_word;

   assign w_step_rise = i_step & ~r_step_d;
   assign w_pc_p1     = r_pc + (AW+1)'(1);
   assign w_cur_word  = r_ram[r_pc[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) r_step_d <= 1'b0;
      else       r_step_d <= i_step;
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_load_en && w_load_ok)
         r_ram[i_load_addr] <= i_load_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_pc     <= '0;
         r_len    <= '0;
         r_din    <= '0;
         r_run    <= 1'b0;
         r_busy   <= 1'b0;
         r_halted <= 1'b0;
         r_error  <= 1'b0;
         r_mvi    <= 1'b0;
         r_wait   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_HALT: begin
               // LoadEn wins; a level Start is then taken on the following cycle.
               if (i_start && !i_load_en) begin
                  r_len   <= i_prog_len;
                  r_pc    <= '0;
                  r_error <= 1'b0;
                  if (i_prog_len == '0) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state  <= S_FETCH;
                     r_halted <= 1'b0;
                     r_busy   <= 1'b1;
                     r_din    <= r_ram[0];
                     r_run    <= fetch_ok(r_ram[0][7:5], (AW+1)'(1), i_prog_len);
                  end
               end
            end
            S_FETCH: begin
               r_run <= 1'b0;
               // Run low in FETCH marks the truncated-mvi case.
               if (!r_run) begin
                  r_state  <= S_HALT;
                  r_error  <= 1'b1;
                  r_halted <= 1'b1;
                  r_busy   <= 1'b0;
               end else begin
                  r_state <= S_EXEC;
                  r_mvi   <= (r_din[7:5] == OP_MVI);
                  r_wait  <= CW'(TIMEOUT - 1);
                  if (r_din[7:5] == OP_MVI) r_din <= r_ram[w_imm_addr];
               end
            end
            S_EXEC: begin
               if (bus.done) begin
                  r_pc <= w_next_pc;
                  if (w_next_pc >= r_len) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                     r_busy   <= 1'b0;
                  end else begin
`ifdef PROC_SEQ_STEP_EN
                     r_state <= S_PAUSE;
`else
                     r_state <= S_FETCH;
                     r_din   <= w_next_word;
                     r_run   <= fetch_ok(w_next_word[7:5], w_next_pc + (AW+1)'(1), r_len);
`endif
                  end
               end else if (r_wait == '0) begin
                  r_state  <= S_HALT;
                  r_error  <= 1'b1;
                  r_halted <= 1'b1;
                  r_busy   <= 1'b0;
               end else begin
                  r_wait <= r_wait - CW'(1);
               end
            end
`ifdef PROC_SEQ_STEP_EN
            S_PAUSE: begin
               if (w_step_rise) begin
                  r_state <= S_FETCH;
                  r_din   <= w_cur_word;
                  r_run   <= fetch_ok(w_cur_word[7:5], w_pc_p1, r_len);
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifndef PROC_SEQ_STEP_EN
   logic w_unused;
   assign w_unused = ^w_next_word;
`endif

   assign bus.din  = r_din;
   assign bus.run  = r_run;
   assign o_pc     = r_pc[AW-1:0];
   assign o_busy   = r_busy;
   assign o_halted = r_halted;
   assign o_error  = r_error;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer with a small behavioural core answering Run/Done.
module tb_proc_sequencer;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [8:0]    load_data;
   logic [AW:0]   prog_len;
   logic          start;
`ifdef PROC_SEQ_STEP_EN
   logic          step;
`endif
   logic [AW-1:0] pc;
   logic          busy, halted, error;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   proc_seq_if bus ();

   proc_sequencer dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_load_en   (load_en),
      .i_load_addr (load_addr),
      .i_load_data (load_data),
      .i_prog_len  (prog_len),
      .i_start     (start),
`ifdef PROC_SEQ_STEP_EN
      .i_step      (step),
`endif
      .bus         (bus),
      .o_pc        (pc),
      .o_busy      (busy),
      .o_halted    (halted),
      .o_error     (error)
   );

   // Behavioural core: mv/mvi answer Done in the first EXEC cycle, add/sub in the third.
   logic       core_en;
   logic [8:0] c_ir;
   logic       c_busy;
   logic [1:0] c_cnt;
   logic [8:0] c_r [4];
   logic [2:0] c_op;
   logic [1:0] c_need;
   assign c_op     = c_ir[7:5];
   assign c_need   = (c_op == 3'b000 || c_op == 3'b001) ? 2'd1 : 2'd3;
   assign bus.done = core_en && c_busy && (c_cnt == c_need);

   always @(posedge clk) begin
      if (rst) begin
         c_busy <= 1'b0;
         c_cnt  <= 2'd0;
      end else if (bus.run) begin
         c_ir   <= bus.din;
         c_busy <= 1'b1;
         c_cnt  <= 2'd1;
      end else if (bus.done) begin
         case (c_op)
            3'b000:  c_r[c_ir[4:3]] <= c_r[c_ir[2:1]];
            3'b001:  c_r[c_ir[4:3]] <= bus.din;
            3'b010:  c_r[c_ir[4:3]] <= c_r[c_ir[4:3]] + c_r[c_ir[2:1]];
            default: c_r[c_ir[4:3]] <= c_r[c_ir[4:3]] - c_r[c_ir[2:1]];
         endcase
         c_busy <= 1'b0;
      end else if (c_busy) begin
         c_cnt <= c_cnt + 2'd1;
      end
   end

   typedef struct {logic [8:0] din; int cyc;} run_t;
   typedef struct {logic err; logic [AW-1:0] pc; int cyc;} halt_t;
   run_t       q_run[$];
   logic [8:0] q_imm[$];
   halt_t      q_halt[$];
   logic       prev_halted = 1'b0;

   // Monitor: every Run pulse, every mvi immediate and every entry into HALT is scored.
   always @(negedge clk) begin
      run_t       r;
      halt_t      h;
      logic [8:0] im;
      if (!rst) begin
         if (bus.run) begin
            checks++;
            if (q_run.size() == 0) begin
               errors++;
               $display("FAIL run_unexpected: din=%h at cycle %0d, required no Run", bus.din, cyc);
            end else begin
               r = q_run.pop_front();
               if (bus.din !== r.din || cyc != r.cyc) begin
                  errors++;
                  $display("FAIL run_pulse: din=%h cycle=%0d, required din=%h cycle=%0d",
                           bus.din, cyc, r.din, r.cyc);
               end
            end
         end
         if (core_en && c_busy && c_cnt == 2'd1 && c_op == 3'b001) begin
            checks++;
            if (q_imm.size() == 0) begin
               errors++;
               $display("FAIL imm_unexpected: din=%h at cycle %0d", bus.din, cyc);
            end else begin
               im = q_imm.pop_front();
               if (bus.din !== im) begin
                  errors++;
                  $display("FAIL mvi_immediate: din=%h, required %h", bus.din, im);
               end
            end
         end
         if (halted && !prev_halted) begin
            checks++;
            if (q_halt.size() == 0) begin
               errors++;
               $display("FAIL halt_unexpected: at cycle %0d", cyc);
            end else begin
               h = q_halt.pop_front();
               if (error !== h.err || pc !== h.pc || cyc != h.cyc) begin
                  errors++;
                  $display("FAIL halt_entry: err=%b pc=%0d cycle=%0d, required err=%b pc=%0d cycle=%0d",
                           error, pc, cyc, h.err, h.pc, h.cyc);
               end
            end
         end
      end
      prev_halted = halted;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [8:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick(1);
      load_en   = 1'b0;
   endtask

   task automatic go(input logic [AW:0] len);
      prog_len = len;
      start    = 1'b1;
      tick(1);
      start    = 1'b0;
   endtask

   task automatic load_prog1();
      load(0, 9'h020);   // mvi R0
      load(1, 9'd5);
      load(2, 9'h028);   // mvi R1
      load(3, 9'd3);
      load(4, 9'h042);   // add R0,R1
   endtask

   int c0;

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; start = 1'b0; core_en = 1'b1;
`ifdef PROC_SEQ_STEP_EN
      step = 1'b0;
`endif
      tick(3);
      rst = 1'b0;
      chk("reset_pc", int'(pc), 0);
      chk("reset_din", int'(bus.din), 0);
      chk("reset_run", int'(bus.run), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_halted", int'(halted), 0);
      chk("reset_error", int'(error), 0);

      load_prog1();
`ifdef PROC_SEQ_STEP_EN
      // Single-step: each Done parks in PAUSE until a Step rising edge.
      c0 = cyc;
      q_run.push_back('{9'h020, c0 + 1});
      q_imm.push_back(9'd5);
      go(5);
      tick(4);
      chk("pause_busy", int'(busy), 1);
      chk("pause_run", int'(bus.run), 0);
      chk("pause_pc", int'(pc), 2);
      load(2, 9'h1FF);
      step = 1'b1;
      q_run.push_back('{9'h028, cyc + 1});
      q_imm.push_back(9'd3);
      tick(1);
      step = 1'b0;
      tick(4);
      chk("pause2_pc", int'(pc), 4);
      chk("pause2_busy", int'(busy), 1);
      step = 1'b1;
      q_run.push_back('{9'h042, cyc + 1});
      q_halt.push_back('{1'b0, 5'd5, cyc + 5});
      tick(1);
      step = 1'b0;
      tick(6);
      chk("step_halted", int'(halted), 1);
      chk("step_r0", int'(c_r[0]), 8);
      do_reset();
      load_prog1();
`else
      // Program: mvi R0,#5; mvi R1,#3; add R0,R1 -- Run at +1,+3,+5, halt at +9.
      c0 = cyc;
      q_run.push_back('{9'h020, c0 + 1});
      q_run.push_back('{9'h028, c0 + 3});
      q_run.push_back('{9'h042, c0 + 5});
      q_imm.push_back(9'd5);
      q_imm.push_back(9'd3);
      q_halt.push_back('{1'b0, 5'd5, c0 + 9});
      go(5);
      tick(1);
      chk("exec_busy", int'(busy), 1);
      chk("exec_run", int'(bus.run), 0);
      load_en = 1'b1; load_addr = 5'd4; load_data = 9'h1FF;   // must be ignored
      tick(1);
      load_en = 1'b0;
      tick(7);
      chk("p1_halted", int'(halted), 1);
      chk("p1_pc", int'(pc), 5);
      chk("p1_error", int'(error), 0);
      chk("p1_busy", int'(busy), 0);
      chk("p1_r0", int'(c_r[0]), 8);
      chk("p1_r1", int'(c_r[1]), 3);

      // Reset while the add is in EXEC.
      do_reset();
      c0 = cyc;
      q_run.push_back('{9'h020, c0 + 1});
      q_run.push_back('{9'h028, c0 + 3});
      q_run.push_back('{9'h042, c0 + 5});
      q_imm.push_back(9'd5);
      q_imm.push_back(9'd3);
      go(5);
      tick(5);
      chk("add_exec_busy", int'(busy), 1);
      chk("add_exec_pc", int'(pc), 4);
      rst = 1'b1;
      tick(1);
      chk("midrst_pc", int'(pc), 0);
      chk("midrst_run", int'(bus.run), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_halted", int'(halted), 0);
      rst = 1'b0;
      tick(1);
`endif

      // Lone mvi word: error, halt, no Run.
      do_reset();
      load(0, 9'h020);
      c0 = cyc;
      q_halt.push_back('{1'b1, 5'd0, c0 + 2});
      go(1);
      tick(2);
      chk("lone_mvi_error", int'(error), 1);
      chk("lone_mvi_halted", int'(halted), 1);

      // Core never answers: 7 EXEC cycles then timeout.
      do_reset();
      core_en = 1'b0;
      load(0, 9'h042);
      c0 = cyc;
      q_run.push_back('{9'h042, c0 + 1});
      q_halt.push_back('{1'b1, 5'd0, c0 + 9});
      go(1);
      tick(7);
      chk("to_still_busy", int'(busy), 1);
      chk("to_not_halted", int'(halted), 0);
      tick(1);
      chk("to_halted", int'(halted), 1);
      chk("to_error", int'(error), 1);
      core_en = 1'b1;

      // From HALT with Error set: ProgLen=0 clears Error and stays halted.
      go(0);
      chk("len0_error", int'(error), 0);
      chk("len0_halted", int'(halted), 1);
      chk("len0_busy", int'(busy), 0);
      tick(3);
      chk("len0_pc", int'(pc), 0);

      chk("runs_pending", q_run.size(), 0);
      chk("imms_pending", q_imm.size(), 0);
      chk("halts_pending", q_halt.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end
endmodule
